// File: rtl/tri_inv_pkg.sv
// Shared types for the triangular-matrix inverse datapath: complex doubles and
// full matrix rows, used by the row arbiter, the inverter and their benches.
package tri_inv_pkg;

    localparam int WIDTH = 64;
    localparam int SIZE  = 16;

    typedef struct packed {
        logic [WIDTH-1:0] im;
        logic [WIDTH-1:0] re;
    } cplx_t;

    typedef cplx_t [SIZE-1:0] row_t;

    localparam int ROW_BITS = $bits(row_t);

endpackage

// File: rtl/tri_inv_row_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among eligible requesters, searching from
// the requester after the last one granted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] eligible_i,
    input  logic         en_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] gnt_idx_s;
    logic          found_s;

    // Rotating priority search starting at ptr_r+1.
    always_comb begin
        logic [PW-1:0] idx;
        grant_o   = '0;
        gnt_idx_s = ptr_r;
        found_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_r) + k) % N);
            if (en_i && !found_s && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                gnt_idx_s    = idx;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer remembers the last granted requester; idle cycles leave it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= PW'(N - 1);
        end else if (found_s) begin
            ptr_r <= gnt_idx_s;
        end
    end

endmodule

// File: rtl/tri_inv_row_arbiter.sv
// Shares the single-port matrix row RAM between the loader (writes) and
// NUM_REQ row readers, gating reads on a per-row written bitmap.
module tri_inv_row_arbiter #(
    parameter int SIZE    = tri_inv_pkg::SIZE,
    parameter int WIDTH   = tri_inv_pkg::WIDTH,
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 1,
    localparam int AW     = $clog2(SIZE),
    localparam int ROW_W  = SIZE * 2 * WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  flush_i,
    input  logic                  wr_valid_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [ROW_W-1:0]      wr_row_i,
    output logic                  wr_ready_o,
    input  logic [NUM_REQ-1:0]    rd_valid_i,
    input  logic [NUM_REQ*AW-1:0] rd_addr_i,
    output logic [NUM_REQ-1:0]    rd_ready_o,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [AW-1:0]         rsp_addr_o,
    output logic [ROW_W-1:0]      rsp_row_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [ROW_W-1:0]      mem_wdata_o,
    input  logic [ROW_W-1:0]      mem_rdata_i,
    output logic [SIZE-1:0]       row_written_o,
    output logic                  busy_o
);

    import tri_inv_pkg::*;

    logic [SIZE-1:0]    row_written_r;
    logic               wr_grant_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] rd_grant_s;
    logic [AW-1:0]      sel_addr_s;
    logic               busy_s;

    logic               mem_en_r;
    logic               mem_we_r;
    logic [AW-1:0]      mem_addr_r;
    logic [ROW_W-1:0]   mem_wdata_r;

    // Stage k holds tags of reads granted k+1 cycles ago; the last stage lines up with RAM data.
    logic [NUM_REQ-1:0] tag_vld_r  [RD_LAT+1];
    logic [AW-1:0]      tag_addr_r [RD_LAT+1];

    assign wr_grant_s = wr_valid_i & ~clear_i & ~rst_i;

    // A reader is eligible only once its row has been loaded.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = rd_valid_i[i] & row_written_r[rd_addr_i[i*AW +: AW]];
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .eligible_i (eligible_s),
        .en_i       (~wr_grant_s & ~rst_i),
        .grant_o    (rd_grant_s)
    );

    // Address of the granted reader.
    always_comb begin
        sel_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_grant_s[i]) begin
                sel_addr_s = rd_addr_i[i*AW +: AW];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Written bitmap; clear and write never coincide since clear blocks the write grant.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            row_written_r <= '0;
        end else if (wr_grant_s) begin
            row_written_r[wr_addr_i] <= 1'b1;
        end
    end

    // Registered RAM port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else if (wr_grant_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= wr_addr_i;
            mem_wdata_r <= wr_row_i;
        end else if (|rd_grant_s) begin
            mem_en_r    <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= sel_addr_s;
        end else begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
        end
    end

    // Response tag pipe; flush kills every stage including the tag entering this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_vld_r[k]  <= '0;
                tag_addr_r[k] <= '0;
            end
        end else begin
            tag_vld_r[0]  <= flush_i ? '0 : rd_grant_s;
            tag_addr_r[0] <= sel_addr_s;
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_vld_r[k]  <= flush_i ? '0 : tag_vld_r[k-1];
                tag_addr_r[k] <= tag_addr_r[k-1];
            end
        end
    end

    // Any tag still travelling means a response is owed.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) begin
            busy_s = busy_s | (|tag_vld_r[k]);
        end
    end

    assign wr_ready_o    = wr_grant_s;
    assign rd_ready_o    = rd_grant_s;
    assign rsp_valid_o   = tag_vld_r[RD_LAT];
    assign rsp_addr_o    = tag_addr_r[RD_LAT];
    assign rsp_row_o     = mem_rdata_i;
    assign mem_en_o      = mem_en_r;
    assign mem_we_o      = mem_we_r;
    assign mem_addr_o    = mem_addr_r;
    assign mem_wdata_o   = mem_wdata_r;
    assign row_written_o = row_written_r;
    assign busy_o        = busy_s;

endmodule

// File: tb/tb_tri_inv_row_arbiter.sv
// Directed bench for tri_inv_row_arbiter with a behavioural RD_LAT=1 row RAM.
module tb_tri_inv_row_arbiter;
    import tri_inv_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int RD_LAT  = 1;
    localparam int AW      = $clog2(SIZE);
    localparam int ROW_W   = SIZE * 2 * WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clear = 1'b0;
    logic                  flush = 1'b0;
    logic                  wr_valid = 1'b0;
    logic [AW-1:0]         wr_addr = '0;
    logic [ROW_W-1:0]      wr_row = '0;
    logic                  wr_ready;
    logic [NUM_REQ-1:0]    rd_valid = '0;
    logic [NUM_REQ*AW-1:0] rd_addr = '0;
    logic [NUM_REQ-1:0]    rd_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [AW-1:0]         rsp_addr;
    logic [ROW_W-1:0]      rsp_row;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [ROW_W-1:0]      mem_wdata;
    logic [ROW_W-1:0]      mem_rdata = '0;
    logic [SIZE-1:0]       row_written;
    logic                  busy;

    logic [ROW_W-1:0]      ram [SIZE];
    int                    pass_cnt = 0;
    int                    total_cnt = 0;

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    tri_inv_row_arbiter #(
        .SIZE(SIZE), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .RD_LAT(RD_LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .flush_i(flush),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_row_i(wr_row), .wr_ready_o(wr_ready),
        .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
        .rsp_valid_o(rsp_valid), .rsp_addr_o(rsp_addr), .rsp_row_o(rsp_row),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .row_written_o(row_written), .busy_o(busy)
    );

    function automatic logic [ROW_W-1:0] make_row(input int r, input int salt);
        row_t row;
        for (int j = 0; j < SIZE; j++) begin
            row[j].re = 64'(salt * 4096 + r * 16 + j);
            row[j].im = ~64'(salt * 4096 + r * 16 + j);
        end
        return row;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        wr_valid = 1'b1; rd_valid = 2'b11; #1;
        total_cnt++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else pass_cnt++;
        total_cnt++; if (rd_ready !== 2'b00) $display("FAIL reset_rd_ready: got %b want 00", rd_ready); else pass_cnt++;
        total_cnt++; if ({mem_en, mem_we, busy} !== 3'b000) $display("FAIL reset_en_we_busy: got %b want 000", {mem_en, mem_we, busy}); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 2'b00 || rsp_addr !== 4'd0 || mem_addr !== 4'd0) $display("FAIL reset_rsp_addr: got %b/%h/%h want 00/0/0", rsp_valid, rsp_addr, mem_addr); else pass_cnt++;
        total_cnt++; if (mem_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", mem_wdata[63:0]); else pass_cnt++;
        total_cnt++; if (row_written !== 16'h0000) $display("FAIL reset_bitmap: got %h want 0000", row_written); else pass_cnt++;
        wr_valid = 1'b0; rd_valid = 2'b00;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_write_all();
        for (int r = 0; r <= SIZE; r++) begin
            @(negedge clk);
            if (r > 0) begin
                total_cnt++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'(r - 1)) $display("FAIL wr_port[%0d]: got en=%b we=%b addr=%0d want 1 1 %0d", r - 1, mem_en, mem_we, mem_addr, r - 1); else pass_cnt++;
                total_cnt++; if (mem_wdata !== make_row(r - 1, 1)) $display("FAIL wr_data[%0d]: got %h want %h", r - 1, mem_wdata[63:0], make_row(r - 1, 1) & 64'hFFFF_FFFF_FFFF_FFFF); else pass_cnt++;
            end
            if (r < SIZE) begin
                wr_valid = 1'b1; wr_addr = 4'(r); wr_row = make_row(r, 1); #1;
                total_cnt++; if (wr_ready !== 1'b1) $display("FAIL wr_ready[%0d]: got %b want 1", r, wr_ready); else pass_cnt++;
            end else begin
                wr_valid = 1'b0; #1;
                total_cnt++; if (row_written !== 16'hFFFF) $display("FAIL bitmap_full: got %h want ffff", row_written); else pass_cnt++;
            end
        end
    endtask

    task automatic test_read_single();
        @(negedge clk); rd_valid = 2'b01; rd_addr = {4'd0, 4'd3}; #1;
        total_cnt++; if (rd_ready !== 2'b01) $display("FAIL rd1_grant: got %b want 01", rd_ready); else pass_cnt++;
        @(negedge clk); rd_valid = 2'b00; #1;
        total_cnt++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd3}) $display("FAIL rd1_port: got %b%b %0d want 1 0 3", mem_en, mem_we, mem_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1 || rsp_valid !== 2'b00) $display("FAIL rd1_busy: got busy=%b rsp=%b want 1 00", busy, rsp_valid); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b01 || rsp_addr !== 4'd3) $display("FAIL rd1_rsp: got %b addr %0d want 01 addr 3", rsp_valid, rsp_addr); else pass_cnt++;
        total_cnt++; if (rsp_row !== make_row(3, 1)) $display("FAIL rd1_data: got %h want %h", rsp_row[63:0], make_row(3, 1) & 64'hFFFF_FFFF_FFFF_FFFF); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL rd1_idle: got rsp=%b busy=%b want 00 0", rsp_valid, busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_gnt [6];
        logic [NUM_REQ-1:0] g;
        int                 a;
        exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 6) begin
                rd_valid = 2'b11; rd_addr = {4'd2, 4'd1};
                wr_valid = (c == 3); wr_addr = 4'd7; wr_row = make_row(7, 1);
            end else begin
                rd_valid = 2'b00; wr_valid = 1'b0;
            end
            #1;
            if (c < 6) begin
                total_cnt++; if (rd_ready !== exp_gnt[c] || wr_ready !== (c == 3)) $display("FAIL rr_grant[%0d]: got rd=%b wr=%b want rd=%b wr=%b", c, rd_ready, wr_ready, exp_gnt[c], c == 3); else pass_cnt++;
            end
            if (c >= 2) begin
                g = exp_gnt[c-2];
                a = (g == 2'b01) ? 1 : 2;
                total_cnt++; if (rsp_valid !== g) $display("FAIL rr_rsp[%0d]: got %b want %b", c, rsp_valid, g); else pass_cnt++;
                if (g != 2'b00) begin
                    total_cnt++; if (rsp_addr !== 4'(a) || rsp_row !== make_row(a, 1)) $display("FAIL rr_rsp_data[%0d]: got addr %0d data %h want addr %0d", c, rsp_addr, rsp_row[63:0], a); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear = 1'b1; wr_valid = 1'b1; wr_addr = 4'd0; wr_row = make_row(0, 3);
        rd_valid = 2'b01; rd_addr = {4'd0, 4'd4}; #1;
        total_cnt++; if (wr_ready !== 1'b0 || rd_ready !== 2'b01) $display("FAIL clr_grant: got wr=%b rd=%b want 0 01", wr_ready, rd_ready); else pass_cnt++;
        @(negedge clk);
        clear = 1'b0; wr_valid = 1'b0; rd_addr = {4'd0, 4'd0}; #1;
        total_cnt++; if (row_written !== 16'h0000 || rd_ready !== 2'b00) $display("FAIL clr_bitmap: got %h rd=%b want 0000 00", row_written, rd_ready); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b01 || rsp_addr !== 4'd4 || rsp_row !== make_row(4, 1)) $display("FAIL clr_inflight: got %b addr %0d data %h want 01 addr 4", rsp_valid, rsp_addr, rsp_row[63:0]); else pass_cnt++;
        total_cnt++; if (rd_ready !== 2'b00) $display("FAIL clr_stall: got %b want 00", rd_ready); else pass_cnt++;
        @(negedge clk); wr_valid = 1'b1; #1;
        total_cnt++; if (wr_ready !== 1'b1 || rd_ready !== 2'b00) $display("FAIL clr_rewrite: got wr=%b rd=%b want 1 00", wr_ready, rd_ready); else pass_cnt++;
        @(negedge clk); wr_valid = 1'b0; #1;
        total_cnt++; if (rd_ready !== 2'b01 || row_written !== 16'h0001) $display("FAIL clr_release: got rd=%b map=%h want 01 0001", rd_ready, row_written); else pass_cnt++;
        @(negedge clk); rd_valid = 2'b00;
        @(negedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b01 || rsp_addr !== 4'd0 || rsp_row !== make_row(0, 3)) $display("FAIL clr_newdata: got %b addr %0d data %h want 01 addr 0", rsp_valid, rsp_addr, rsp_row[63:0]); else pass_cnt++;
    endtask

    task automatic test_pending();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); rd_valid = 2'b10; rd_addr = {4'd5, 4'd0}; #1;
            total_cnt++; if (rd_ready !== 2'b00 || busy !== 1'b0) $display("FAIL pend_stall[%0d]: got rd=%b busy=%b want 00 0", c, rd_ready, busy); else pass_cnt++;
        end
        @(negedge clk); wr_valid = 1'b1; wr_addr = 4'd5; wr_row = make_row(5, 4); #1;
        total_cnt++; if (wr_ready !== 1'b1 || rd_ready !== 2'b00) $display("FAIL pend_write: got wr=%b rd=%b want 1 00", wr_ready, rd_ready); else pass_cnt++;
        @(negedge clk); wr_valid = 1'b0; #1;
        total_cnt++; if (rd_ready !== 2'b10) $display("FAIL pend_grant: got %b want 10", rd_ready); else pass_cnt++;
        @(negedge clk); rd_valid = 2'b00;
        @(negedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b10 || rsp_addr !== 4'd5 || rsp_row !== make_row(5, 4)) $display("FAIL pend_rsp: got %b addr %0d data %h want 10 addr 5", rsp_valid, rsp_addr, rsp_row[63:0]); else pass_cnt++;
    endtask

    task automatic test_flush();
        @(negedge clk); rd_valid = 2'b01; rd_addr = {4'd0, 4'd0}; #1;
        total_cnt++; if (rd_ready !== 2'b01) $display("FAIL fl_grant0: got %b want 01", rd_ready); else pass_cnt++;
        @(negedge clk); flush = 1'b1; #1;
        total_cnt++; if (rd_ready !== 2'b01 || busy !== 1'b1) $display("FAIL fl_grant1: got rd=%b busy=%b want 01 1", rd_ready, busy); else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); flush = 1'b0; rd_valid = 2'b00; #1;
            total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL fl_quiet[%0d]: got rsp=%b busy=%b want 00 0", c, rsp_valid, busy); else pass_cnt++;
        end
        @(negedge clk); rd_valid = 2'b10; rd_addr = {4'd5, 4'd0}; #1;
        total_cnt++; if (rd_ready !== 2'b10) $display("FAIL fl_after_grant: got %b want 10", rd_ready); else pass_cnt++;
        @(negedge clk); rd_valid = 2'b00;
        @(negedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b10 || rsp_addr !== 4'd5 || rsp_row !== make_row(5, 4)) $display("FAIL fl_after_rsp: got %b addr %0d data %h want 10 addr 5", rsp_valid, rsp_addr, rsp_row[63:0]); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        @(negedge clk); rd_valid = 2'b01; rd_addr = {4'd0, 4'd0}; #1;
        total_cnt++; if (rd_ready !== 2'b01) $display("FAIL rm_grant: got %b want 01", rd_ready); else pass_cnt++;
        @(negedge clk); rst = 1'b1; rd_valid = 2'b00;
        @(negedge clk); rst = 1'b0; #1;
        total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || row_written !== 16'h0000) $display("FAIL rm_state: got rsp=%b busy=%b map=%h want 00 0 0000", rsp_valid, busy, row_written); else pass_cnt++;
        @(negedge clk); wr_valid = 1'b1; wr_addr = 4'd0; wr_row = make_row(0, 5); #1;
        total_cnt++; if (rsp_valid !== 2'b00 || wr_ready !== 1'b1) $display("FAIL rm_quiet: got rsp=%b wr=%b want 00 1", rsp_valid, wr_ready); else pass_cnt++;
        @(negedge clk); wr_valid = 1'b0; rd_valid = 2'b11; rd_addr = {4'd0, 4'd0}; #1;
        total_cnt++; if (rd_ready !== 2'b01) $display("FAIL rm_ptr: got %b want 01", rd_ready); else pass_cnt++;
        @(negedge clk); rd_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_read_single();
        test_round_robin();
        test_clear();
        test_pending();
        test_flush();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tri_inv_row_arbiter.md
# tri_inv_row_arbiter

Shares the single-port matrix row buffer that feeds the triangular-matrix inverse engine among one row writer (the matrix loader) and NUM_REQ row readers (the inverter's row fetch port plus auxiliary consumers). It keeps a per-row written bitmap so readers can start on row r as soon as the loader has written it, and it returns read data in order with a one-hot requester tag. It sits between the row RAM and the inverter's `mat_row_addr_o` / `mat_row_i` interface.

## Interface
- `SIZE`, 16: matrix rows, and complex elements per row.
- `WIDTH`, 64: bits per real/imag part (IEEE double).
- `NUM_REQ`, 2: read requesters, 2..4.
- `RD_LAT`, 1: row RAM read latency in cycles, 1..3.
- Derived: `AW = $clog2(SIZE)`, `ROW_W = SIZE*2*WIDTH`. Element j occupies bits [j*2*WIDTH +: 2*WIDTH], laid out {imag, real}.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `clear_i` in 1: clears the written bitmap (starts a new matrix).
- `flush_i` in 1: drops all in-flight read responses.
- `wr_valid_i` in 1, `wr_addr_i` in AW, `wr_row_i` in ROW_W: loader write request.
- `wr_ready_o` out 1: write accepted.
- `rd_valid_i` in NUM_REQ, `rd_addr_i` in NUM_REQ×AW: read requests.
- `rd_ready_o` out NUM_REQ: one-hot read grant.
- `rsp_valid_o` out NUM_REQ: one-hot response tag.
- `rsp_addr_o` out AW, `rsp_row_o` out ROW_W: response address and data.
- `mem_en_o` out 1, `mem_we_o` out 1, `mem_addr_o` out AW, `mem_wdata_o` out ROW_W: RAM port.
- `mem_rdata_i` in ROW_W: RAM read data.
- `row_written_o` out SIZE: written bitmap.
- `busy_o` out 1: any read in flight.

## Operation
- Grant logic is combinational and evaluated every cycle. At most one grant per cycle.
- Priority 1: the write. If `wr_valid_i` and `clear_i` is low, assert `wr_ready_o` and grant no read.
- Priority 2: reads. A read requester i is eligible iff `rd_valid_i[i]` and `row_written[rd_addr_i[i]]`. Among eligible requesters, grant round-robin starting at `rr_ptr+1` (mod NUM_REQ).
- On a read grant, `rr_ptr` becomes the granted index. `rr_ptr` does not move on write or idle cycles.
- Requests for unwritten rows stay pending with no grant. They are never dropped.
- Accepted op at cycle T: the RAM port is registered, so `mem_en_o` is high at T+1 with the address, `mem_we_o`, and data of the op.
- Write accepted at T: `row_written[addr]` sets at T+1.
- Read accepted at T: the tag {one-hot i, addr} enters a RD_LAT+1 deep shift pipe.
- Response: `rsp_valid_o`, `rsp_addr_o`, and `rsp_row_o = mem_rdata_i` are asserted at T+1+RD_LAT, for exactly one cycle. There is no backpressure; requesters must sink every response.
- RAM semantics are read-before-write. Rewriting a valid row while a read of it is in flight returns the old data. Reads granted after the rewrite return the new data.
- `clear_i`:
  - bitmap → 0 next cycle.
  - Blocks write grants that cycle.
  - Reads that cycle see the old bitmap.
  - In-flight reads complete normally.
- `flush_i`: clears every tag valid bit next cycle, so no `rsp_valid_o` follows from ops accepted at or before the flush cycle. Grants in the flush cycle are still made and are also discarded.
- `busy_o` = OR of tag valid bits.

## Timing
- Reset values:
  - `wr_ready_o`, `rd_ready_o`, `rsp_valid_o`, `mem_en_o`, `mem_we_o`, `busy_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `rsp_addr_o` = 0.
  - bitmap = 0.
  - `rr_ptr` = NUM_REQ-1, so requester 0 wins first.
- `rd_ready_o` / `wr_ready_o` are combinational. The first grant is possible in the first cycle after `rst_i` deasserts.
- `rsp_row_o` is a wire from `mem_rdata_i`, qualified only by `rsp_valid_o`.
- Read latency: 1+RD_LAT cycles from grant to response. Throughput is one op per cycle.
- Reset mid-operation: all tags, bitmap, and pointer return to reset values. No responses are issued for pre-reset reads.

## Structure
- Shared package `tri_inv_pkg` holds `WIDTH`, `SIZE`, a `cplx_t` typedef ({imag, real} doubles), and `row_t` (SIZE × `cplx_t`). The inverter and its benches use the same package.
- One sub-module: `rr_arbiter` (parameter N: req/eligible in, one-hot grant out, pointer update on an enable).
- The tag pipe, bitmap, and RAM port registers live in the top module.

## Test plan
1. Reset, then write rows 0..15 back-to-back → `wr_ready_o` high for 16 cycles, `mem_we_o` at T+1, `row_written_o` = 16'hFFFF after the last write.
2. RD_LAT=1, requester 0 reads row 3 at T → `rsp_valid_o` = 2'b01 at T+2, `rsp_addr_o` = 3, data equals the written row.
3. Both requesters assert continuously on written rows → grants alternate 0,1,0,1. The write asserted mid-stream wins that cycle with no read grant.
4. Requester 1 reads row 5 before it is written → no grant. Loader writes row 5 at T → grant at T+1 or later, response carries the new data.
5. Three reads in flight, `flush_i` pulsed → no `rsp_valid_o` from them, `busy_o` low two cycles later. A later read responds normally.
6. `clear_i` with `wr_valid_i` high → no write grant that cycle and bitmap 0. A read to row 0 then stalls until row 0 is rewritten.
